// File: rtl/snake_pkg.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | Module   : snake_pkg                                                      |
// | Purpose  : Shared types and helpers for the snake body engine: movement  |
// |            direction encoding, game state encoding and the reversal      |
// |            helper used to reject 180-degree turns.                       |
// | Revision : 1.0 - initial release                                         |
// +--------------------------------------------------------------------------+
package snake_pkg;

    // Direction encoding matches the 2-bit dir input from the control logic.
    typedef enum logic [1:0] {
        UP    = 2'd0,
        DOWN  = 2'd1,
        LEFT  = 2'd2,
        RIGHT = 2'd3
    } dir_t;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DEAD = 2'd2
    } state_t;

    // Direction pointing the opposite way; a request equal to this is a
    // reversal into the neck and is discarded.
    function automatic dir_t opposite(input dir_t d);
        case (d)
            UP:      return DOWN;
            DOWN:    return UP;
            LEFT:    return RIGHT;
            default: return LEFT;
        endcase
    endfunction

endpackage
`default_nettype wire

// File: rtl/snake_cell_match.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | Module   : snake_cell_match                                               |
// | Purpose  : MAX_LEN parallel comparators between one grid cell and the    |
// |            stored body segments. Only segments with index < matchLen     |
// |            can match; stale entries beyond the body never hit.           |
// | Ports    : segX/segY  - segment coordinate arrays (index 0 = head)       |
// |            matchLen   - number of leading segments eligible to match     |
// |            cellX/cellY- cell under test                                  |
// |            hit        - some eligible segment equals the cell            |
// | Revision : 1.0 - initial release                                         |
// +--------------------------------------------------------------------------+
module snake_cell_match
    import snake_pkg::*;
#(
    parameter int MAX_LEN = 64,
    parameter int XW      = 6,
    parameter int YW      = 5,
    parameter int LW      = 7
) (
    input  logic [XW-1:0] segX [MAX_LEN],
    input  logic [YW-1:0] segY [MAX_LEN],
    input  logic [LW-1:0] matchLen,
    input  logic [XW-1:0] cellX,
    input  logic [YW-1:0] cellY,
    output logic          hit
);

    logic [MAX_LEN-1:0] w_match;

    generate
        for (genvar i = 0; i < MAX_LEN; i++) begin : g_cmp
            assign w_match[i] = (LW'(i) < matchLen) &&
                                (segX[i] == cellX) &&
                                (segY[i] == cellY);
        end
    endgenerate

    assign hit = |w_match;

endmodule
`default_nettype wire

// File: rtl/snake_body_engine.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | Module   : snake_body_engine                                              |
// | Purpose  : Holds the snake body as a shift array of grid cells and       |
// |            advances it on each game tick. Handles growth, wall/wrap      |
// |            edges, self-collision, reversal rejection and a registered    |
// |            per-pixel body/head query for the video path.                 |
// | Ports    : clock, resetN            - clock, async active-low reset      |
// |            start, step, dir, grow   - game control                       |
// |            wallsOn                  - 1: edges kill, 0: edges wrap       |
// |            pixX, pixY               - pixel query coordinates            |
// |            bodyHit, headHit         - registered query result            |
// |            headX, headY, length     - body status                        |
// |            gameOver, running        - DEAD / RUN state flags             |
// | Revision : 1.0 - initial release                                         |
// +--------------------------------------------------------------------------+
module snake_body_engine
    import snake_pkg::*;
#(
    parameter int GRID_W    = 40,
    parameter int GRID_H    = 30,
    parameter int MAX_LEN   = 64,
    parameter int INIT_LEN  = 3,
    parameter int CELL_LOG2 = 4,
    parameter int PIX_W     = 10
) (
    input  logic                           clock,
    input  logic                           resetN,
    input  logic                           start,
    input  logic                           step,
    input  logic [1:0]                     dir,
    input  logic                           grow,
    input  logic                           wallsOn,
    input  logic [PIX_W-1:0]               pixX,
    input  logic [PIX_W-1:0]               pixY,
    output logic                           bodyHit,
    output logic                           headHit,
    output logic [$clog2(GRID_W)-1:0]      headX,
    output logic [$clog2(GRID_H)-1:0]      headY,
    output logic [$clog2(MAX_LEN+1)-1:0]   length,
    output logic                           gameOver,
    output logic                           running
);

    localparam int XW = $clog2(GRID_W);
    localparam int YW = $clog2(GRID_H);
    localparam int LW = $clog2(MAX_LEN + 1);

    localparam logic [XW-1:0] c_xMax   = XW'(GRID_W - 1);
    localparam logic [YW-1:0] c_yMax   = YW'(GRID_H - 1);
    localparam logic [LW-1:0] c_maxLen = LW'(MAX_LEN);

    // ------------------------------------------------------------------
    // State
    // ------------------------------------------------------------------
    state_t        r_state;
    state_t        w_stateNext;
    dir_t          r_curDir;
    logic [XW-1:0] r_segX [MAX_LEN];
    logic [YW-1:0] r_segY [MAX_LEN];
    logic [LW-1:0] r_length;
    logic [LW-1:0] r_pendGrow;

    // ------------------------------------------------------------------
    // Step evaluation
    // ------------------------------------------------------------------
    dir_t          w_dirReq;
    dir_t          w_dirRes;
    logic [XW-1:0] w_nextX;
    logic [YW-1:0] w_nextY;
    logic          w_wallHit;
    logic          w_grows;
    logic [LW-1:0] w_collLen;
    logic          w_selfHit;
    logic          w_doStep;
    logic          w_die;
    logic          w_advance;
    logic [LW-1:0] w_pendAfterStep;
    logic [LW-1:0] w_pendNext;

    assign w_dirReq = dir_t'(dir);
    assign w_dirRes = (w_dirReq == opposite(r_curDir)) ? r_curDir : w_dirReq;

    // Edges are compared explicitly so non-power-of-two grids wrap correctly.
    always_comb begin
        w_nextX   = r_segX[0];
        w_nextY   = r_segY[0];
        w_wallHit = 1'b0;
        case (w_dirRes)
            UP: begin
                if (r_segY[0] == '0) begin
                    w_wallHit = wallsOn;
                    w_nextY   = c_yMax;
                end else begin
                    w_nextY = r_segY[0] - 1'b1;
                end
            end
            DOWN: begin
                if (r_segY[0] == c_yMax) begin
                    w_wallHit = wallsOn;
                    w_nextY   = '0;
                end else begin
                    w_nextY = r_segY[0] + 1'b1;
                end
            end
            LEFT: begin
                if (r_segX[0] == '0) begin
                    w_wallHit = wallsOn;
                    w_nextX   = c_xMax;
                end else begin
                    w_nextX = r_segX[0] - 1'b1;
                end
            end
            default: begin
                if (r_segX[0] == c_xMax) begin
                    w_wallHit = wallsOn;
                    w_nextX   = '0;
                end else begin
                    w_nextX = r_segX[0] + 1'b1;
                end
            end
        endcase
    end

    assign w_grows = (r_pendGrow != '0) && (r_length < c_maxLen);

    // When not growing the tail cell is vacated this same step, so it is
    // left out of the collision set.
    assign w_collLen = (w_grows || (r_length == '0)) ? r_length : (r_length - 1'b1);

    snake_cell_match #(
        .MAX_LEN (MAX_LEN),
        .XW      (XW),
        .YW      (YW),
        .LW      (LW)
    ) u_collMatch (
        .segX     (r_segX),
        .segY     (r_segY),
        .matchLen (w_collLen),
        .cellX    (w_nextX),
        .cellY    (w_nextY),
        .hit      (w_selfHit)
    );

    // start has priority; a step in the same cycle is dropped.
    assign w_doStep  = step && !start && (r_state == RUN);
    assign w_die     = w_doStep && (w_wallHit || w_selfHit);
    assign w_advance = w_doStep && !w_die;

    // The step consumes the old pending count; a grow in the same cycle is
    // added afterwards and saturates at MAX_LEN.
    assign w_pendAfterStep = (w_advance && w_grows) ? (r_pendGrow - 1'b1) : r_pendGrow;
    assign w_pendNext      = (grow && (w_pendAfterStep < c_maxLen)) ?
                             (w_pendAfterStep + 1'b1) : w_pendAfterStep;

    // ------------------------------------------------------------------
    // FSM
    // ------------------------------------------------------------------
    always_ff @(posedge clock or negedge resetN) begin
        if (!resetN) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_stateNext;
        end
    end

    always_comb begin
        w_stateNext = r_state;
        running     = 1'b0;
        gameOver    = 1'b0;
        case (r_state)
            RUN:     running  = 1'b1;
            DEAD:    gameOver = 1'b1;
            default: ;
        endcase
        if (start) begin
            w_stateNext = RUN;
        end else if (w_die) begin
            w_stateNext = DEAD;
        end
    end

    // ------------------------------------------------------------------
    // Body storage
    // ------------------------------------------------------------------
    always_ff @(posedge clock or negedge resetN) begin
        if (!resetN) begin
            for (int i = 0; i < MAX_LEN; i++) begin
                r_segX[i] <= '0;
                r_segY[i] <= '0;
            end
            r_length   <= '0;
            r_pendGrow <= '0;
            r_curDir   <= RIGHT;
        end else if (start) begin
            // Horizontal body extending left of the grid centre.
            for (int i = 0; i < MAX_LEN; i++) begin
                if (i < INIT_LEN) begin
                    r_segX[i] <= XW'(GRID_W / 2 - i);
                    r_segY[i] <= YW'(GRID_H / 2);
                end
            end
            r_length   <= LW'(INIT_LEN);
            r_pendGrow <= '0;
            r_curDir   <= RIGHT;
        end else begin
            if (r_state == RUN) begin
                r_pendGrow <= w_pendNext;
            end
            if (w_advance) begin
                for (int i = MAX_LEN - 1; i > 0; i--) begin
                    r_segX[i] <= r_segX[i-1];
                    r_segY[i] <= r_segY[i-1];
                end
                r_segX[0] <= w_nextX;
                r_segY[0] <= w_nextY;
                r_curDir  <= w_dirRes;
                if (w_grows) begin
                    r_length <= r_length + 1'b1;
                end
            end
        end
    end

    assign headX  = r_segX[0];
    assign headY  = r_segY[0];
    assign length = r_length;

    // ------------------------------------------------------------------
    // Pixel query
    // ------------------------------------------------------------------
    logic [PIX_W-1:0] w_qCellXFull;
    logic [PIX_W-1:0] w_qCellYFull;
    logic [XW-1:0]    w_qCellX;
    logic [YW-1:0]    w_qCellY;
    logic             w_qInGrid;
    logic             w_qBody;

    assign w_qCellXFull = pixX >> CELL_LOG2;
    assign w_qCellYFull = pixY >> CELL_LOG2;
    assign w_qInGrid    = (w_qCellXFull < PIX_W'(GRID_W)) && (w_qCellYFull < PIX_W'(GRID_H));
    assign w_qCellX     = w_qCellXFull[XW-1:0];
    assign w_qCellY     = w_qCellYFull[YW-1:0];

    snake_cell_match #(
        .MAX_LEN (MAX_LEN),
        .XW      (XW),
        .YW      (YW),
        .LW      (LW)
    ) u_queryMatch (
        .segX     (r_segX),
        .segY     (r_segY),
        .matchLen (r_length),
        .cellX    (w_qCellX),
        .cellY    (w_qCellY),
        .hit      (w_qBody)
    );

    always_ff @(posedge clock or negedge resetN) begin
        if (!resetN) begin
            bodyHit <= 1'b0;
            headHit <= 1'b0;
        end else begin
            bodyHit <= (r_state != IDLE) && w_qInGrid && w_qBody;
            headHit <= (r_state != IDLE) && w_qInGrid &&
                       (r_segX[0] == w_qCellX) && (r_segY[0] == w_qCellY);
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_snake_body_engine.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | Module   : tb_snake_body_engine                                           |
// | Purpose  : Self-checking bench for snake_body_engine. A queue-based game |
// |            model predicts every output each cycle; directed scenarios    |
// |            add hand-computed literal expectations.                       |
// | Revision : 1.0 - initial release                                         |
// +--------------------------------------------------------------------------+
module tb_snake_body_engine;

    localparam int GW = 40;
    localparam int GH = 30;
    localparam int ML = 64;
    localparam int IL = 3;

    logic       clock = 1'b0;
    logic       resetN;
    logic       start, step, grow, wallsOn;
    logic [1:0] dir;
    logic [9:0] pixX, pixY;
    logic       bodyHit, headHit, gameOver, running;
    logic [5:0] headX;
    logic [4:0] headY;
    logic [6:0] length;

    snake_body_engine dut (
        .clock    (clock),
        .resetN   (resetN),
        .start    (start),
        .step     (step),
        .dir      (dir),
        .grow     (grow),
        .wallsOn  (wallsOn),
        .pixX     (pixX),
        .pixY     (pixY),
        .bodyHit  (bodyHit),
        .headHit  (headHit),
        .headX    (headX),
        .headY    (headY),
        .length   (length),
        .gameOver (gameOver),
        .running  (running)
    );

    always #5 clock = ~clock;

    int nVec = 0;
    int nMis = 0;
    bit checkEn = 0;

    task automatic chk(input string name, input int act, input int exp);
        nVec++;
        if (act != exp) begin
            nMis++;
            $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
        end
    endtask

    // ------------------------------------------------------------------
    // Game model: the body is a queue of cells, head at the front.
    // ------------------------------------------------------------------
    int mState;          // 0 idle, 1 run, 2 dead
    int mX[$];
    int mY[$];
    int mPend;
    int mDir;
    bit mBody, mHead;
    int cx, cy, d, nx, ny, lim;
    bit wall, hit, growing;

    always @(posedge clock or negedge resetN) begin
        if (!resetN) begin
            mState = 0; mX.delete(); mY.delete();
            mPend = 0; mDir = 3; mBody = 0; mHead = 0;
        end else begin
            cx = int'(pixX) / 16;
            cy = int'(pixY) / 16;
            mBody = 0; mHead = 0;
            if (mState != 0 && cx < GW && cy < GH) begin
                foreach (mX[i]) if (mX[i] == cx && mY[i] == cy) mBody = 1;
                if (mX[0] == cx && mY[0] == cy) mHead = 1;
            end
            if (start) begin
                mState = 1; mX.delete(); mY.delete();
                for (int i = 0; i < IL; i++) begin
                    mX.push_back(GW/2 - i);
                    mY.push_back(GH/2);
                end
                mPend = 0; mDir = 3;
            end else if (mState == 1) begin
                if (step) begin
                    d = int'(dir);
                    if (d == (mDir ^ 1)) d = mDir;   // up/down and left/right pairs
                    nx = mX[0]; ny = mY[0]; wall = 0;
                    case (d)
                        0: ny = ny - 1;
                        1: ny = ny + 1;
                        2: nx = nx - 1;
                        default: nx = nx + 1;
                    endcase
                    if (nx < 0 || nx >= GW || ny < 0 || ny >= GH) begin
                        wall = wallsOn;
                        nx = (nx + GW) % GW;
                        ny = (ny + GH) % GH;
                    end
                    growing = (mPend > 0) && (mX.size() < ML);
                    lim = growing ? mX.size() : mX.size() - 1;
                    hit = 0;
                    for (int i = 0; i < lim; i++) if (mX[i] == nx && mY[i] == ny) hit = 1;
                    if (wall || hit) begin
                        mState = 2;
                    end else begin
                        mX.push_front(nx); mY.push_front(ny); mDir = d;
                        if (growing) mPend--;
                        else begin mX.pop_back(); void'(mY.pop_back()); end
                    end
                end
                if (grow && mPend < ML) mPend++;
            end
        end
    end

    always @(negedge clock) begin
        if (checkEn) begin
            chk("m_headX",    headX,    (mX.size() > 0) ? mX[0] : 0);
            chk("m_headY",    headY,    (mY.size() > 0) ? mY[0] : 0);
            chk("m_length",   length,   mX.size());
            chk("m_running",  running,  int'(mState == 1));
            chk("m_gameOver", gameOver, int'(mState == 2));
            chk("m_bodyHit",  bodyHit,  mBody);
            chk("m_headHit",  headHit,  mHead);
        end
    end

    // One clock of stimulus; returns at the next falling edge.
    task automatic cyc(input bit s, input bit st, input logic [1:0] dv, input bit g);
        start = s; step = st; dir = dv; grow = g;
        @(negedge clock);
        start = 0; step = 0; grow = 0;
    endtask

    initial begin
        resetN = 0; start = 0; step = 0; dir = 2'd3; grow = 0; wallsOn = 1;
        pixX = 10'd320; pixY = 10'd240;
        repeat (2) @(negedge clock);
        chk("rst_running",  running,  0);
        chk("rst_gameOver", gameOver, 0);
        chk("rst_length",   length,   0);
        chk("rst_headX",    headX,    0);
        chk("rst_bodyHit",  bodyHit,  0);
        resetN = 1; checkEn = 1;

        // IDLE: query gives nothing, step ignored
        cyc(0, 1, 3, 1);
        chk("idle_bodyHit", bodyHit, 0);
        chk("idle_length",  length,  0);

        // Start and three steps right
        cyc(1, 0, 3, 0);
        chk("start_headX", headX, 20);
        chk("start_headY", headY, 15);
        chk("start_len",   length, 3);
        cyc(0, 1, 3, 0);
        chk("start_headHit_q", headHit, 1);
        cyc(0, 1, 3, 0);
        cyc(0, 1, 3, 0);
        chk("step3_headX", headX, 23);
        chk("step3_len",   length, 3);
        pixX = 10'd368; pixY = 10'd240;
        cyc(0, 0, 3, 0);
        chk("q368_body", bodyHit, 1);
        chk("q368_head", headHit, 1);
        pixX = 10'd1023; pixY = 10'd1023;
        cyc(0, 0, 3, 0);
        chk("q_offgrid", bodyHit, 0);
        pixX = 10'd336; pixY = 10'd240;

        // start and step together: start wins
        cyc(1, 1, 3, 0);
        chk("startstep_headX", headX, 20);

        // Reversal ignored
        cyc(0, 1, 2, 0);
        chk("rev_headX", headX, 21);
        chk("rev_headY", headY, 15);

        // Wall kill
        repeat (18) cyc(0, 1, 3, 0);
        chk("wall_pre_headX", headX, 39);
        cyc(0, 1, 3, 0);
        chk("wall_gameOver", gameOver, 1);
        chk("wall_headX",    headX,    39);
        cyc(0, 1, 0, 1);
        chk("dead_headY", headY, 15);

        // Wrap mode
        wallsOn = 0;
        cyc(1, 0, 3, 0);
        repeat (19) cyc(0, 1, 3, 0);
        cyc(0, 1, 3, 0);
        chk("wrap_headX",   headX,   0);
        chk("wrap_running", running, 1);
        pixX = 10'd0;
        repeat (16) cyc(0, 1, 0, 0);
        chk("wrap_headY", headY, 29);

        // Growth
        wallsOn = 1;
        cyc(1, 0, 3, 0);
        cyc(0, 0, 3, 1);
        cyc(0, 0, 3, 1);
        cyc(0, 1, 3, 0);
        chk("grow_len4", length, 4);
        cyc(0, 1, 3, 0);
        chk("grow_len5", length, 5);
        cyc(0, 1, 3, 0);
        chk("grow_len5b", length, 5);
        cyc(0, 1, 3, 1);
        chk("growstep_len", length, 5);
        cyc(0, 1, 3, 0);
        chk("growstep_len6", length, 6);

        // Fill to MAX_LEN along a serpentine path
        wallsOn = 0;
        pixY = 10'd240;
        cyc(1, 0, 3, 0);
        repeat (70) cyc(0, 0, 3, 1);
        for (int r = 0; r < 4; r++) begin
            for (int i = 0; i < 30; i++) begin
                pixX = 10'(i * 16);
                cyc(0, 1, (r % 2 == 0) ? 2'd3 : 2'd2, 0);
            end
            cyc(0, 1, 0, 0);
        end
        chk("fill_len", length, 64);
        cyc(0, 1, 0, 1);
        cyc(0, 1, 0, 0);
        chk("fill_sat_len", length, 64);

        // Self collision with length 5
        wallsOn = 1;
        pixX = 10'd336; pixY = 10'd224;
        cyc(1, 0, 3, 0);
        cyc(0, 0, 3, 1);
        cyc(0, 0, 3, 1);
        cyc(0, 1, 3, 0);
        cyc(0, 1, 3, 0);
        chk("loop_len", length, 5);
        cyc(0, 1, 0, 0);
        cyc(0, 1, 2, 0);
        cyc(0, 1, 1, 0);
        chk("loop_gameOver", gameOver, 1);
        chk("loop_headX",    headX,    21);
        chk("loop_headY",    headY,    14);

        // Moving into the vacating tail with length 4
        cyc(1, 0, 3, 0);
        cyc(0, 0, 3, 1);
        cyc(0, 1, 3, 0);
        chk("tail_len", length, 4);
        cyc(0, 1, 0, 0);
        cyc(0, 1, 2, 0);
        cyc(0, 1, 1, 0);
        chk("tail_running", running, 1);
        chk("tail_headX",   headX,   20);
        chk("tail_headY",   headY,   15);

        // Asynchronous reset mid-run
        cyc(0, 1, 3, 0);
        #2 resetN = 0;
        #1;
        chk("arst_running", running, 0);
        chk("arst_length",  length,  0);
        chk("arst_headX",   headX,   0);
        chk("arst_headY",   headY,   0);
        chk("arst_headHit", headHit, 0);
        @(negedge clock);
        resetN = 1;
        cyc(0, 1, 3, 0);
        chk("arst_step_running", running, 0);
        chk("arst_step_length",  length,  0);
        repeat (2) cyc(0, 0, 3, 0);

        $display("== %0d vectors applied, %0d miscompares ==", nVec, nMis);
        $finish;
    end

endmodule
`default_nettype wire
